mem_access_unit: RTL and testbench

- Load/store sequencer between the multi-cycle CPU control/datapath and the byte-addressed word Memory.
- Accepts one load or store request at a time and drives MemRd, MemWr, addr and W_data of Memory.
- Consumes R_data from Memory and returns sign- or zero-extended data to the datapath.
- Implements byte and halfword stores as a read-modify-write of the containing aligned word; flags misaligned, out-of-range and bad-size requests.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between CPU datapath and a byte-addressed word Memory.
// Sub-word stores are done as read-modify-write of the containing aligned word.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        MemRd,
  output logic        MemWr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  code_q, code_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] rdata_q, rdata_d;
  logic        memrd_q, memrd_d;
  logic        memwr_q, memwr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  function automatic logic [1:0] req_check(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11)
      return 2'b11;
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00))
      return 2'b01;
    if (({1'b0, a[31:2], 2'b00} + 33'd3) >= 33'(MEM_BYTES))
      return 2'b10;
    return 2'b00;
  endfunction

  // Little-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return sx ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sx ? {{16{h[15]}}, h} : {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (sz == 2'b00)
      m[{lane, 3'b000} +: 8] = wd[7:0];
    else
      m[{lane[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    code_d      = code_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          sext_d     = sign_ext;
          lane_d     = addr[1:0];
          wdata_d    = wdata[15:0];
          code_d     = req_check(size, addr);
          mem_addr_d = {addr[31:2], 2'b00};
          if (code_d != 2'b00) begin
            state_d = RESP;
          end else if (we && size == 2'b10) begin
            state_d     = WR;
            mem_wdata_d = wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        // The fetched word is consumed at this edge, either merged or extracted.
        if (we_q) begin
          state_d     = WR;
          mem_wdata_d = store_merge(mem_rdata, size_q, lane_q, wdata_q);
        end else begin
          state_d = RESP;
          rdata_d = load_extract(mem_rdata, size_q, lane_q, sext_q);
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase

    memrd_d    = (state_d == RD);
    memwr_d    = (state_d == WR);
    ready_d    = (state_d == RESP);
    err_d      = ready_d && (code_d != 2'b00);
    err_code_d = ready_d ? code_d : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      code_q      <= 2'b00;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      rdata_q     <= 32'h0;
      memrd_q     <= 1'b0;
      memwr_q     <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      code_q      <= code_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      rdata_q     <= rdata_d;
      memrd_q     <= memrd_d;
      memwr_q     <= memwr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ready     = ready_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign rdata     = rdata_q;
  assign MemRd     = memrd_q;
  assign MemWr     = memwr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array Memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, err, MemRd, MemWr;
  logic [1:0]  err_code;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err),
    .err_code(err_code), .MemRd(MemRd), .MemWr(MemWr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge; preload port for setup.
  logic [7:0] mem [0:1023];
  logic       pre_we = 1'b0;
  logic [9:0] pre_addr = 10'h0;
  logic [7:0] pre_data = 8'h0;
  logic [9:0] wb;
  assign wb = {mem_addr[9:2], 2'b00};
  assign mem_rdata = MemRd ? {mem[wb + 10'd3], mem[wb + 10'd2], mem[wb + 10'd1], mem[wb]} : 32'h0;

  always @(posedge clk) begin
    if (MemWr) begin
      mem[wb]         <= mem_wdata[7:0];
      mem[wb + 10'd1] <= mem_wdata[15:8];
      mem[wb + 10'd2] <= mem_wdata[23:16];
      mem[wb + 10'd3] <= mem_wdata[31:24];
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  function automatic logic [31:0] peek(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  int          r_lat, r_rd, r_wr;
  logic [31:0] r_rdata, r_ra, r_wa, r_wd;
  logic        r_err;
  logic [1:0]  r_code;

  task automatic run(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
    bit done;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    r_lat = 0; r_rd = 0; r_wr = 0; done = 1'b0;
    r_ra = 32'hFFFF_FFFF; r_wa = 32'hFFFF_FFFF; r_wd = 32'hFFFF_FFFF;
    r_rdata = 32'h0; r_err = 1'b0; r_code = 2'b00;
    while (!done && r_lat < 10) begin
      @(negedge clk);
      r_lat++;
      if (MemRd) begin r_rd++; r_ra = mem_addr; end
      if (MemWr) begin r_wr++; r_wa = mem_addr; r_wd = mem_wdata; end
      if (MemRd && MemWr) chk("rd_wr_overlap", 32'd1, 32'd0);
      if (ready) begin
        done = 1'b1; r_rdata = rdata; r_err = err; r_code = err_code;
      end
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready), 32'd0);
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] exp);
    run(1'b0, sz, sx, a, 32'h0);
    chk({tag, "_lat"}, r_lat, 32'd2);
    chk({tag, "_rdata"}, r_rdata, exp);
    chk({tag, "_err"}, 32'(r_err), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [1:0] code, input logic [31:0] keep);
    run(w, sz, 1'b0, a, 32'h5555_5555);
    chk({tag, "_lat"}, r_lat, 32'd1);
    chk({tag, "_err"}, 32'(r_err), 32'd1);
    chk({tag, "_code"}, 32'(r_code), 32'(code));
    chk({tag, "_mem_cycles"}, r_rd + r_wr, 32'd0);
    chk({tag, "_rdata_hold"}, r_rdata, keep);
  endtask

  initial begin
    int rdy_cnt, rd_cnt;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_memrd", 32'(MemRd), 32'd0);
    chk("rst_memwr", 32'(MemWr), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    poke(10'h10, 8'hBB); poke(10'h11, 8'hAA); poke(10'h12, 8'h99); poke(10'h13, 8'h88);
    poke(10'h3FC, 8'h01); poke(10'h3FD, 8'h02); poke(10'h3FE, 8'h03); poke(10'h3FF, 8'h84);
    @(negedge clk) rst_n = 1'b1;

    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("ldw_lat", r_lat, 32'd2);
    chk("ldw_rdata", r_rdata, 32'h8899AABB);
    chk("ldw_rd_cycles", r_rd, 32'd1);
    chk("ldw_wr_cycles", r_wr, 32'd0);
    chk("ldw_mem_addr", r_ra, 32'h10);
    chk("ldw_err", 32'(r_err), 32'd0);

    load_chk("ldb_s13", 2'b00, 1'b1, 32'h13, 32'hFFFFFF88);
    load_chk("ldb_u13", 2'b00, 1'b0, 32'h13, 32'h00000088);
    load_chk("ldh_s12", 2'b01, 1'b1, 32'h12, 32'hFFFF8899);
    load_chk("ldh_u10", 2'b01, 1'b0, 32'h10, 32'h0000AABB);
    load_chk("ldb_s11", 2'b00, 1'b1, 32'h11, 32'hFFFFFFAA);
    load_chk("ldw_sx", 2'b10, 1'b1, 32'h10, 32'h8899AABB);

    run(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677);
    chk("stb_lat", r_lat, 32'd3);
    chk("stb_rd_cycles", r_rd, 32'd1);
    chk("stb_wr_cycles", r_wr, 32'd1);
    chk("stb_wr_addr", r_wa, 32'h10);
    chk("stb_wdata", r_wd, 32'h889977BB);
    chk("stb_rdata_hold", r_rdata, 32'h8899AABB);
    load_chk("stb_readback", 2'b10, 1'b0, 32'h10, 32'h889977BB);

    run(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD5566);
    chk("sth_lat", r_lat, 32'd3);
    chk("sth_wdata", r_wd, 32'h556677BB);
    load_chk("sth_readback", 2'b10, 1'b0, 32'h10, 32'h556677BB);

    err_chk("e_mis_half", 1'b0, 2'b01, 32'h11, 2'b01, 32'h556677BB);
    err_chk("e_oor_word", 1'b0, 2'b10, 32'h400, 2'b10, 32'h556677BB);
    err_chk("e_bad_size", 1'b0, 2'b11, 32'h10, 2'b11, 32'h556677BB);
    err_chk("e_size_prio", 1'b0, 2'b11, 32'h401, 2'b11, 32'h556677BB);
    err_chk("e_mis_store", 1'b1, 2'b10, 32'h22, 2'b01, 32'h556677BB);
    err_chk("e_oor_byte", 1'b1, 2'b00, 32'h403, 2'b10, 32'h556677BB);
    chk("e_mem_intact", peek(32'h10), 32'h556677BB);

    load_chk("edge_w3fc", 2'b10, 1'b0, 32'h3FC, 32'h84030201);
    load_chk("edge_b3ff", 2'b00, 1'b1, 32'h3FF, 32'hFFFFFF84);

    // Abort a halfword store while it is in the write cycle.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h12; wdata = 32'h0000DEAD;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk) chk("abort_rd", 32'(MemRd), 32'd1);
    @(negedge clk) chk("abort_wr", 32'(MemWr), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", 32'(MemWr), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem", peek(32'h10), 32'h556677BB);
    rst_n = 1'b1;

    run(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    chk("stw_lat", r_lat, 32'd2);
    chk("stw_rd_cycles", r_rd, 32'd0);
    chk("stw_wr_cycles", r_wr, 32'd1);
    chk("stw_wdata", r_wd, 32'hCAFEF00D);
    chk("stw_err", 32'(r_err), 32'd0);
    load_chk("stw_readback", 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);

    // req held high: only IDLE-cycle samples start a transaction.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h20;
    rdy_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) begin
        rdy_cnt++;
        chk("busy_rdata", rdata, 32'hCAFEF00D);
      end
      if (MemRd) rd_cnt++;
    end
    req = 1'b0;
    chk("busy_ready_cnt", rdy_cnt, 32'd3);
    chk("busy_rd_cnt", rd_cnt, 32'd3);
    repeat (3) @(negedge clk);
    chk("busy_quiet", 32'({ready, MemRd, MemWr}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
